// File: rtl/spi_dac_with_fifo_rd.sv
// Pops a 12-bit sample from a byte-wide FIFO (low byte, then high nibble)
// and shifts it to an SPI DAC as a 16-bit frame {CTRL, sample}, MSB first.
// sclk is a divided register output (mode 0), not a clock.
module spi_dac_with_fifo_rd #(
  parameter int unsigned CLK_DIV = 5,
  parameter logic [3:0]  CTRL    = 4'b0011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StCapLo,
    StRdHi,
    StCapHi,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             sclk_q, sclk_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       lo_q, lo_d;
  logic [15:0]      shreg_q, shreg_d;
  logic             div_tc;

  assign div_tc = (div_q == DivW'(CLK_DIV - 1));
  assign sclk   = sclk_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      sclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      lo_q      <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      bit_cnt_q <= bit_cnt_d;
      lo_q      <= lo_d;
      shreg_q   <= shreg_d;
    end
  end

  // Next-state logic and decoded outputs.
  always_comb begin
    state_d    = state_q;
    div_d      = '0;
    sclk_d     = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    lo_d       = lo_q;
    shreg_d    = shreg_q;
    fifo_rd_en = 1'b0;
    cs_n       = 1'b1;
    mosi       = 1'b0;
    busy       = (state_q != StIdle);
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        if (enable && !fifo_empty) state_d = StRdLo;
      end
      StRdLo: begin
        // Pop is never issued against an empty FIFO; wait for data instead.
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = StCapLo;
        end
      end
      StCapLo: begin
        lo_d    = fifo_dout;
        state_d = StRdHi;
      end
      StRdHi: begin
        // Underflow: hold here with cs_n high until the high byte arrives.
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = StCapHi;
        end
      end
      StCapHi: begin
        shreg_d   = {CTRL, fifo_dout[3:0], lo_q};
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        cs_n   = 1'b0;
        mosi   = shreg_q[15];
        sclk_d = sclk_q;
        if (div_tc) begin
          div_d  = '0;
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end else begin
            // Falling toggle: advance data while sclk is low.
            shreg_d = shreg_q << 1;
            if (bit_cnt_q == 5'd16) state_d = StDone;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_spi_dac_with_fifo_rd.sv
// Directed bench for spi_dac_with_fifo_rd: a FIFO model feeds two DUTs
// (CLK_DIV=5 and CLK_DIV=2); sel picks which one is active and observed.
module tb_spi_dac_with_fifo_rd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty;

  logic rd1, cs1, sclk1, mosi1, busy1, done1;
  logic rd2, cs2, sclk2, mosi2, busy2, done2;
  logic rd_m, cs_m, sclk_m, mosi_m, busy_m, done_m;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // FIFO model: pointers written by separate processes.
  logic [7:0] mem [0:63];
  logic [5:0] wr_ptr = 6'd0;
  logic [5:0] rd_ptr = 6'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_m && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 6'd1;
    end
  end

  spi_dac_with_fifo_rd #(.CLK_DIV(5), .CTRL(4'b0011)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable & ~sel),
    .fifo_empty (fifo_empty | sel),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (rd1),
    .cs_n       (cs1),
    .sclk       (sclk1),
    .mosi       (mosi1),
    .busy       (busy1),
    .done       (done1)
  );

  spi_dac_with_fifo_rd #(.CLK_DIV(2), .CTRL(4'b0011)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable & sel),
    .fifo_empty (fifo_empty | ~sel),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (rd2),
    .cs_n       (cs2),
    .sclk       (sclk2),
    .mosi       (mosi2),
    .busy       (busy2),
    .done       (done2)
  );

  assign rd_m   = sel ? rd2   : rd1;
  assign cs_m   = sel ? cs2   : cs1;
  assign sclk_m = sel ? sclk2 : sclk1;
  assign mosi_m = sel ? mosi2 : mosi1;
  assign busy_m = sel ? busy2 : busy1;
  assign done_m = sel ? done2 : done1;

  // Monitor: monotonic totals sampled on the falling clk edge.
  int          n_rd = 0, n_rise = 0, n_done = 0, n_mosi_bad = 0;
  int          cs_run = 0, hi_run = 0, last_cs_low = 0, last_cs_high = 0;
  logic [15:0] frame_sr = 16'h0, last_frame = 16'h0;
  logic        sclk_prev = 1'b0, mosi_prev = 1'b0, cs_prev = 1'b1;

  always @(negedge clk) begin
    if (rd_m) n_rd++;
    if (sclk_m && !sclk_prev) begin
      n_rise++;
      frame_sr = {frame_sr[14:0], mosi_m};
      if (mosi_m !== mosi_prev) n_mosi_bad++;
    end
    if (done_m) begin
      n_done++;
      last_frame = frame_sr;
    end
    if (!cs_m) cs_run++;
    else if (!cs_prev) begin
      last_cs_low = cs_run;
      cs_run = 0;
    end
    if (cs_m) hi_run++;
    else if (cs_prev) begin
      last_cs_high = hi_run;
      hi_run = 0;
    end
    sclk_prev = sclk_m;
    mosi_prev = mosi_m;
    cs_prev   = cs_m;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (n_done >= target) break;
      cyc(1);
    end
  endtask

  task automatic test_reset();
    enable = 1'b0;
    reset  = 1'b1;
    cyc(2);
    n_checks++;
    if ({rd1, cs1, sclk1, mosi1, busy1, done1} !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 010000",
               {rd1, cs1, sclk1, mosi1, busy1, done1});
    end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_single_frame();
    int s_rd, s_rise, s_done;
    s_rd = n_rd; s_rise = n_rise; s_done = n_done;
    push(8'h34); push(8'h02);
    enable = 1'b1;
    wait_done(s_done + 1);
    cyc(5);
    n_checks++;
    if (n_done - s_done !== 1) begin
      n_fail++; $display("FAIL single_done_count: got %0d want 1", n_done - s_done);
    end
    n_checks++;
    if (last_frame !== 16'h3234) begin
      n_fail++; $display("FAIL single_frame: got %h want 3234", last_frame);
    end
    n_checks++;
    if (n_rd - s_rd !== 2) begin
      n_fail++; $display("FAIL single_rd_count: got %0d want 2", n_rd - s_rd);
    end
    n_checks++;
    if (n_rise - s_rise !== 16) begin
      n_fail++; $display("FAIL single_sclk_rises: got %0d want 16", n_rise - s_rise);
    end
    n_checks++;
    if (last_cs_low !== 160) begin
      n_fail++; $display("FAIL single_cs_low: got %0d want 160", last_cs_low);
    end
    n_checks++;
    if (fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL single_fifo_empty: got %b want 1", fifo_empty);
    end
  endtask

  task automatic test_underflow();
    int s_rd, s_done;
    s_rd = n_rd; s_done = n_done;
    push(8'hAB);
    enable = 1'b1;
    cyc(20);
    n_checks++;
    if (n_rd - s_rd !== 1) begin
      n_fail++; $display("FAIL underflow_rd_count: got %0d want 1", n_rd - s_rd);
    end
    n_checks++;
    if ({cs1, busy1, sclk1} !== 3'b110) begin
      n_fail++; $display("FAIL underflow_stall: cs_n/busy/sclk got %b want 110",
                         {cs1, busy1, sclk1});
    end
    push(8'hFF);
    wait_done(s_done + 1);
    cyc(2);
    n_checks++;
    if (last_frame !== 16'h3FAB || n_done - s_done !== 1) begin
      n_fail++; $display("FAIL underflow_frame: got %h/%0d want 3fab/1",
                         last_frame, n_done - s_done);
    end
  endtask

  task automatic test_back_to_back();
    int s_done;
    s_done = n_done;
    push(8'h00); push(8'h00); push(8'hFF); push(8'h0F);
    enable = 1'b1;
    wait_done(s_done + 1);
    n_checks++;
    if (last_frame !== 16'h3000) begin
      n_fail++; $display("FAIL b2b_frame0: got %h want 3000", last_frame);
    end
    wait_done(s_done + 2);
    cyc(5);
    n_checks++;
    if (last_frame !== 16'h3FFF) begin
      n_fail++; $display("FAIL b2b_frame1: got %h want 3fff", last_frame);
    end
    n_checks++;
    if (last_cs_high < 5) begin
      n_fail++; $display("FAIL b2b_cs_gap: got %0d want >=5", last_cs_high);
    end
    n_checks++;
    if (n_done - s_done !== 2) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d want 2", n_done - s_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s_rise, s_rd, s_done;
    s_rise = n_rise;
    push(8'h12); push(8'h03);
    enable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (n_rise - s_rise >= 7) break;
      cyc(1);
    end
    n_checks++;
    if (n_rise - s_rise !== 7) begin
      n_fail++; $display("FAIL midreset_reach: got %0d rises want 7", n_rise - s_rise);
    end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    n_checks++;
    if ({cs1, sclk1, busy1, done1} !== 4'b1000) begin
      n_fail++; $display("FAIL midreset_outputs: cs_n/sclk/busy/done got %b want 1000",
                         {cs1, sclk1, busy1, done1});
    end
    s_rd = n_rd; s_done = n_done;
    cyc(30);
    n_checks++;
    if (n_rd - s_rd !== 0 || n_done - s_done !== 0) begin
      n_fail++; $display("FAIL midreset_quiet: rd %0d done %0d want 0 0",
                         n_rd - s_rd, n_done - s_done);
    end
  endtask

  task automatic test_enable();
    int s_rd, s_done, low_cnt;
    enable = 1'b0;
    push(8'h5A); push(8'h0C);
    s_rd = n_rd; s_done = n_done; low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (cs1 !== 1'b1) low_cnt++;
    end
    n_checks++;
    if (n_rd - s_rd !== 0 || low_cnt !== 0) begin
      n_fail++; $display("FAIL enable_off: rd %0d cs_low %0d want 0 0",
                         n_rd - s_rd, low_cnt);
    end
    enable = 1'b1;
    cyc(3);
    enable = 1'b0;
    wait_done(s_done + 1);
    cyc(2);
    n_checks++;
    if (n_done - s_done !== 1 || last_frame !== 16'h3C5A) begin
      n_fail++; $display("FAIL enable_drop: done %0d frame %h want 1 3c5a",
                         n_done - s_done, last_frame);
    end
  endtask

  task automatic test_fast_div();
    int s_rise, s_done, s_bad;
    sel = 1'b1;
    do_reset();
    s_rise = n_rise; s_done = n_done; s_bad = n_mosi_bad;
    push(8'h96); push(8'h07);
    enable = 1'b1;
    wait_done(s_done + 1);
    cyc(2);
    n_checks++;
    if (last_frame !== 16'h3796 || n_done - s_done !== 1) begin
      n_fail++; $display("FAIL fast_frame: got %h/%0d want 3796/1",
                         last_frame, n_done - s_done);
    end
    n_checks++;
    if (last_cs_low !== 64) begin
      n_fail++; $display("FAIL fast_cs_low: got %0d want 64", last_cs_low);
    end
    n_checks++;
    if (n_rise - s_rise !== 16 || n_mosi_bad - s_bad !== 0) begin
      n_fail++; $display("FAIL fast_sclk: rises %0d unstable %0d want 16 0",
                         n_rise - s_rise, n_mosi_bad - s_bad);
    end
    enable = 1'b0;
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    enable = 1'b0;
    test_underflow();
    enable = 1'b0;
    test_back_to_back();
    enable = 1'b0;
    do_reset();
    test_reset_mid_frame();
    enable = 1'b0;
    do_reset();
    test_enable();
    test_fast_div();
    n_checks++;
    if (n_mosi_bad !== 0) begin
      n_fail++; $display("FAIL mosi_stable_at_rise: got %0d unstable want 0", n_mosi_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
